// File: rtl/seg7_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_msg_sequencer
//  Purpose  : Scrolls a fixed character message across one common-anode
//             seven-segment digit. Characters advance either on a free-running
//             prescaler tick (run=1) or on manual step pulses (run=0), forward
//             or reverse, looping or stopping once at the end of the message.
//
//  Ports    : io_in[0]    clock, all state on its rising edge
//             io_in[1]    reset, asynchronous, active-high
//             io_in[2]    run    (1 = auto-advance, 0 = paused)
//             io_in[3]    dir    (0 = forward, 1 = reverse)
//             io_in[4]    mode   (0 = loop, 1 = one-shot)
//             io_in[5]    step   (rising edge advances one char while paused)
//             io_in[7:6]  speed  (dwell = 2^(DWELL_BITS-2*speed) clocks)
//             io_out[6:0] segments {G,F,E,D,C,B,A}, active-low, registered
//             io_out[7]   decimal point, active-low, lit once done
//
//  Revision : 1.0  initial release
// ============================================================================
module seg7_msg_sequencer #(
    parameter int                    MSG_LEN    = 12,
    parameter int                    DWELL_BITS = 24,
    parameter logic [5*MSG_LEN-1:0]  MSG        = {5'h1F, 5'h1F, 5'h0C, 5'h11,
                                                   5'h05, 5'h0A, 5'h1F, 5'h00,
                                                   5'h12, 5'h12, 5'h0E, 5'h10}
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int                  c_IDX_W = $clog2(MSG_LEN);
    localparam logic [c_IDX_W-1:0]  c_LAST  = c_IDX_W'(MSG_LEN - 1);
    localparam logic [DWELL_BITS-1:0] c_ONES = {DWELL_BITS{1'b1}};

    logic clk;
    logic rst;
    assign clk = io_in[0];
    assign rst = io_in[1];

    // ------------------------------------------------------------------
    // Two-stage synchronisers for the asynchronous control inputs
    // ------------------------------------------------------------------
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= io_in[7:2];
            r_sync2 <= r_sync1;
        end
    end

    logic       w_run;
    logic       w_dir;
    logic       w_mode;
    logic       w_step;
    logic [1:0] w_speed;

    assign w_run   = r_sync2[0];
    assign w_dir   = r_sync2[1];
    assign w_mode  = r_sync2[2];
    assign w_step  = r_sync2[3];
    assign w_speed = r_sync2[5:4];

    // ------------------------------------------------------------------
    // Message storage viewed as an array of 5-bit character codes
    // ------------------------------------------------------------------
    logic [4:0] w_chars [MSG_LEN];

    generate
        for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_chars
            assign w_chars[gi] = MSG[5*gi +: 5];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Glyph table, active-low segments {G,F,E,D,C,B,A}
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_glyph(input logic [4:0] code);
        logic [6:0] seg;
        seg = 7'h7F;
        case (code)
            5'h00: seg = 7'h40;   // 0 / O
            5'h01: seg = 7'h79;   // 1
            5'h02: seg = 7'h24;   // 2
            5'h03: seg = 7'h30;   // 3
            5'h04: seg = 7'h19;   // 4
            5'h05: seg = 7'h12;   // 5 / S
            5'h06: seg = 7'h02;   // 6
            5'h07: seg = 7'h78;   // 7
            5'h08: seg = 7'h00;   // 8
            5'h09: seg = 7'h10;   // 9
            5'h0A: seg = 7'h08;   // A
            5'h0B: seg = 7'h03;   // b
            5'h0C: seg = 7'h46;   // C
            5'h0D: seg = 7'h21;   // d
            5'h0E: seg = 7'h06;   // E
            5'h0F: seg = 7'h0E;   // F
            5'h10: seg = 7'h09;   // H
            5'h11: seg = 7'h4F;   // I
            5'h12: seg = 7'h47;   // L
            5'h13: seg = 7'h0C;   // P
            5'h14: seg = 7'h41;   // U
            default: seg = 7'h7F; // blank
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [DWELL_BITS-1:0] r_presc;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_done;
    logic                  r_step_d;
    logic                  r_run_d;
    logic                  r_mode_d;
    logic [7:0]            r_out;

    logic [DWELL_BITS-1:0] w_mask;
    logic                  w_tick;
    logic                  w_step_evt;
    logic                  w_advance;
    logic                  w_restart;
    logic [6:0]            w_glyph;

    // Each speed step removes two prescaler bits from the terminal-count
    // compare, i.e. divides the dwell by four.
    assign w_mask     = c_ONES >> {w_speed, 1'b0};
    assign w_tick     = w_run && ((r_presc & w_mask) == w_mask);
    assign w_step_evt = w_step & ~r_step_d & ~w_run;
    assign w_advance  = w_tick | w_step_evt;
    // Restart on run rising, or on leaving one-shot mode.
    assign w_restart  = (w_run & ~r_run_d) | (~w_mode & r_mode_d);
    assign w_glyph    = f_glyph(w_chars[r_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_step_d <= 1'b0;
            r_run_d  <= 1'b0;
            r_mode_d <= 1'b0;
            r_out    <= 8'hFF;
        end else begin
            r_step_d <= w_step;
            r_run_d  <= w_run;
            r_mode_d <= w_mode;

            if (w_run) begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_restart) begin
                r_done <= 1'b0;
                r_idx  <= w_dir ? c_LAST : '0;
            end else if (w_advance && !r_done) begin
                if (!w_dir) begin
                    if (r_idx == c_LAST) begin
                        if (w_mode) begin
                            r_done <= 1'b1;
                        end else begin
                            r_idx <= '0;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end else begin
                    if (r_idx == '0) begin
                        if (w_mode) begin
                            r_done <= 1'b1;
                        end else begin
                            r_idx <= c_LAST;
                        end
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
            end

            // Display reflects the index/done state of the previous clock.
            r_out <= {~r_done, w_glyph};
        end
    end

    assign io_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_seg7_msg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_msg_sequencer
//  Purpose  : Directed self-checking bench for seg7_msg_sequencer with an
//             8-bit prescaler: loop/reverse scrolling, direction change,
//             one-shot stop and restart, manual stepping, dwell timing,
//             speed change and asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_msg_sequencer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       run   = 1'b0;
    logic       dir   = 1'b0;
    logic       mode  = 1'b0;
    logic       step  = 1'b0;
    logic [1:0] speed = 2'd0;

    wire  [7:0] io_in;
    wire  [7:0] io_out;

    assign io_in = {speed, step, mode, dir, run, rst, clk};

    seg7_msg_sequencer #(
        .DWELL_BITS (8)
    ) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for the display to change; returns clocks waited.
    task automatic wait_change(input int bound, output int cnt);
        logic [7:0] prev;
        prev = io_out;
        cnt  = 0;
        while (io_out == prev && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Wait (bounded) for a specific display value.
    task automatic wait_for(input logic [7:0] val, input int bound);
        int cnt;
        cnt = 0;
        while (io_out != val && cnt < bound) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic reset_release();
        rst = 1'b1;
        clocks(3);
        rst = 1'b0;
        clocks(1);
    endtask

    // Forward message glyphs starting at index 2, wrapping to index 1
    logic [7:0] fwd_seq [12] = '{8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'h88, 8'h92,
                                 8'hCF, 8'hC6, 8'hFF, 8'hFF, 8'h89, 8'h86};
    // Reverse glyphs starting at index 8
    logic [7:0] rev_seq [5]  = '{8'hCF, 8'h92, 8'h88, 8'hFF, 8'hC0};

    initial begin
        int c;
        int c2;
        logic [7:0] prev;

        // ---------------- reset state and forward loop ----------------
        rst = 1'b1; run = 1'b1; speed = 2'd3; dir = 1'b0; mode = 1'b0;
        clocks(4);
        check("reset_out", io_out, 8'hFF);
        rst = 1'b0;
        clocks(1);
        check("first_glyph", io_out, 8'h89);
        wait_change(20, c);
        check("fwd_char1", io_out, 8'h86);
        check("first_dwell_clks", c, 6);
        for (int i = 0; i < 12; i++) begin
            prev = io_out;
            clocks(3);
            check("fwd_hold", io_out, prev);
            clocks(1);
            check("fwd_seq", io_out, fwd_seq[i]);
        end

        // ---------------- reverse from reset ----------------
        dir = 1'b1;
        reset_release();
        check("rev_first", io_out, 8'h89);
        wait_change(10, c);
        check("rev_idx11", io_out, 8'hFF);
        wait_change(12, c);
        check("rev_idx9", io_out, 8'hC6);
        for (int i = 0; i < 5; i++) begin
            clocks(4);
            check("rev_seq", io_out, rev_seq[i]);
        end

        // ---------------- direction change at index 4 ----------------
        dir = 1'b0;
        clocks(4);
        check("dirchg_idx5", io_out, 8'hFF);
        clocks(4);
        check("dirchg_idx6", io_out, 8'h88);

        // ---------------- one-shot ----------------
        mode = 1'b1;
        reset_release();
        wait_for(8'h7F, 100);
        check("oneshot_done", io_out, 8'h7F);
        clocks(64);
        check("oneshot_hold", io_out, 8'h7F);
        run = 1'b0;
        clocks(8);
        check("paused_done", io_out, 8'h7F);
        run = 1'b1;
        wait_change(10, c);
        check("run_restart", io_out, 8'h89);
        wait_for(8'h7F, 100);
        check("oneshot_done2", io_out, 8'h7F);
        mode = 1'b0;
        wait_change(10, c);
        check("mode_restart", io_out, 8'h89);

        // ---------------- manual stepping ----------------
        run = 1'b0;
        reset_release();
        check("step_first", io_out, 8'h89);
        clocks(10);
        check("paused_hold", io_out, 8'h89);
        step = 1'b1; clocks(6);
        check("step1", io_out, 8'h86);
        step = 1'b0; clocks(6);
        step = 1'b1; clocks(20);
        check("step_held", io_out, 8'hC7);
        step = 1'b0; clocks(6);
        step = 1'b1; clocks(6);
        step = 1'b0; clocks(6);
        step = 1'b1; clocks(6);
        check("step4", io_out, 8'hC0);
        step = 1'b0; clocks(6);
        run = 1'b1;
        wait_change(10, c);
        check("step_run_restart", io_out, 8'h89);
        check("step_restart_clks", c, 4);
        wait_change(10, c);
        check("frozen_presc", io_out, 8'h86);
        check("frozen_presc_clks", c, 3);

        // ---------------- slowest speed, step ignored, speed change ----------------
        speed = 2'd0;
        reset_release();
        check("slow_first", io_out, 8'h89);
        wait_change(300, c);
        check("slow_char1", io_out, 8'h86);
        check("slow_first_clks", c, 258);
        clocks(50);
        step = 1'b1; clocks(6);
        step = 1'b0; clocks(6);
        check("run_step_ignored", io_out, 8'h86);
        wait_change(300, c2);
        check("slow_char2", io_out, 8'hC7);
        check("dwell_256", c2 + 62, 256);
        clocks(356);
        speed = 2'd3;
        wait_change(8, c);
        check("speed_change", io_out, 8'hC0);

        // ---------------- asynchronous reset mid-message ----------------
        reset_release();
        wait_for(8'h92, 60);
        check("mid_idx7", io_out, 8'h92);
        rst = 1'b1;
        #1;
        check("async_reset", io_out, 8'hFF);
        clocks(3);
        rst = 1'b0;
        clocks(1);
        check("post_reset", io_out, 8'h89);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
